// File: rtl/cordic_ci_master.sv
// cordic_ci_master: streams FP32 angles to a multicycle custom-instruction CORDIC slave and returns cosine results
// Ports:
//   clock_i, aclr_n_i             clock and asynchronous active-low reset
//   in_valid_i/in_ready_o/in_data_i     angle input handshake
//   out_valid_o/out_ready_i/out_data_o/out_err_o  result output handshake (out_err_o marks a timeout)
//   ci_clk_en_o, ci_start_o, ci_aclr_o, ci_dataa_o, ci_result_i, ci_done_i  custom-instruction slave port
//   op_count_o (wrapping), err_count_o (saturating)  operation statistics
module cordic_ci_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clock_i,
  input  logic        aclr_n_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_err_o,
  output logic        ci_clk_en_o,
  output logic        ci_start_o,
  output logic        ci_aclr_o,
  output logic [31:0] ci_dataa_o,
  input  logic [31:0] ci_result_i,
  input  logic        ci_done_i,
  output logic [15:0] op_count_o,
  output logic [7:0]  err_count_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;
  localparam logic [7:0] TMAX  = 8'(TIMEOUT - 1);
  logic [1:0]  state_q, state_d;
  logic [31:0] dataa_q, dataa_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_err_q, out_err_d;
  logic [7:0]  timer_q, timer_d;
  logic [15:0] op_cnt_q, op_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        aclr_q;
  // in_ready is gated by the reset pin so it reads 0 while held in reset
  assign in_ready_o  = (state_q == IDLE) && aclr_n_i;
  assign ci_start_o  = state_q == ISSUE;
  assign ci_clk_en_o = (state_q == ISSUE) || (state_q == WAIT);
  assign out_valid_o = state_q == HOLD;
  assign out_data_o  = out_data_q;
  assign out_err_o   = out_err_q;
  assign ci_dataa_o  = dataa_q;
  assign ci_aclr_o   = aclr_q;
  assign op_count_o  = op_cnt_q;
  assign err_count_o = err_cnt_q;
  always_comb begin
    state_d    = state_q;
    dataa_d    = dataa_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    timer_d    = timer_q;
    op_cnt_d   = op_cnt_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: if (in_valid_i && in_ready_o) begin
        dataa_d = in_data_i;
        state_d = ISSUE;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 8'd1;
        // done is checked first so a completion on the last allowed cycle is not an error
        if (ci_done_i) begin
          out_data_d = ci_result_i;
          out_err_d  = 1'b0;
          state_d    = HOLD;
        end else if (timer_q == TMAX) begin
          out_data_d = '0;
          out_err_d  = 1'b1;
          err_cnt_d  = err_cnt_q + {7'd0, ~&err_cnt_q};
          state_d    = HOLD;
        end
      end
      default: if (out_ready_i) begin
        op_cnt_d = op_cnt_q + 16'd1;
        state_d  = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      state_q    <= IDLE;
      dataa_q    <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      timer_q    <= '0;
      op_cnt_q   <= '0;
      err_cnt_q  <= '0;
      aclr_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      dataa_q    <= dataa_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      timer_q    <= timer_d;
      op_cnt_q   <= op_cnt_d;
      err_cnt_q  <= err_cnt_d;
      aclr_q     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cordic_ci_master.sv
// tb_cordic_ci_master: randomized directed checks of cordic_ci_master against an operation-level model
module tb_cordic_ci_master;
  localparam int TO = 64;
  logic        clock = 1'b0;
  logic        aclr_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        ci_done = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] ci_result = '0;
  logic        in_ready, out_valid, out_err, ci_clk_en, ci_start, ci_aclr;
  logic [31:0] out_data, ci_dataa;
  logic [15:0] op_count;
  logic [7:0]  err_count;
  int n_cmp = 0;
  int n_bad = 0;
  int m_ops = 0;
  int m_errs = 0;
  always #5 clock = ~clock;
  cordic_ci_master #(.TIMEOUT(TO)) dut (
    .clock_i(clock), .aclr_n_i(aclr_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_err_o(out_err),
    .ci_clk_en_o(ci_clk_en), .ci_start_o(ci_start), .ci_aclr_o(ci_aclr), .ci_dataa_o(ci_dataa),
    .ci_result_i(ci_result), .ci_done_i(ci_done),
    .op_count_o(op_count), .err_count_o(err_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask
  // lat: cycles after the ISSUE cycle at which the slave raises done (0 = never)
  task automatic run_op(input logic [31:0] a, input int lat, input logic [31:0] res, input int stall, input bit stale);
    int c;
    bit hit;
    int exp_c;
    logic [31:0] exp_d;
    hit = (lat > 0) && (lat <= TO);
    exp_c = hit ? lat + 1 : TO + 1;
    exp_d = hit ? res : 32'd0;
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data = a;
    ci_done = stale;
    ci_result = $urandom;
    cyc();
    in_valid = 1'b0;
    in_data = $urandom;
    chk("issue_start", ci_start, 1);
    chk("issue_clk_en", ci_clk_en, 1);
    chk("issue_dataa", ci_dataa, a);
    chk("issue_in_ready", in_ready, 0);
    c = 0;
    do begin
      cyc();
      c++;
      if (!out_valid) begin
        chk("wait_start", ci_start, 0);
        chk("wait_clk_en", ci_clk_en, 1);
        ci_done = (lat > 0) && (c >= lat);
        ci_result = ci_done ? res : $urandom;
      end
    end while (!out_valid && c < 3 * TO);
    ci_done = 1'b0;
    chk("valid_cycle", c, exp_c);
    chk("out_data", out_data, exp_d);
    chk("out_err", out_err, {31'd0, !hit});
    chk("hold_clk_en", ci_clk_en, 0);
    chk("hold_in_ready", in_ready, 0);
    chk("hold_dataa", ci_dataa, a);
    if (!hit) m_errs = (m_errs == 255) ? 255 : m_errs + 1;
    chk("err_count", err_count, m_errs);
    for (int i = 0; i < stall; i++) begin
      cyc();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, exp_d);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_clk_en", ci_clk_en, 0);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    m_ops = (m_ops + 1) & 16'hFFFF;
    chk("done_valid", out_valid, 0);
    chk("op_count", op_count, m_ops);
    chk("post_in_ready", in_ready, 1);
  endtask
  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_ci_start", ci_start, 0);
    chk("rst_ci_clk_en", ci_clk_en, 0);
    chk("rst_ci_dataa", ci_dataa, 0);
    chk("rst_ci_aclr", ci_aclr, 1);
    chk("rst_op_count", op_count, 0);
    chk("rst_err_count", err_count, 0);
  endtask
  initial begin
    int lat;
    repeat (3) @(negedge clock);
    chk_reset_vals();
    aclr_n = 1'b1;
    #1;
    chk("rel_ci_aclr", ci_aclr, 1);
    chk("rel_in_ready", in_ready, 1);
    cyc();
    chk("rel2_ci_aclr", ci_aclr, 0);
    run_op(32'h3F000000, 17, $urandom, 0, 1'b0);
    run_op($urandom, 17, $urandom, 0, 1'b1);
    run_op($urandom, 12, $urandom, 10, 1'b0);
    run_op($urandom, TO, $urandom, 0, 1'b0);
    run_op($urandom, TO + 1, $urandom, 0, 1'b0);
    run_op($urandom, 0, $urandom, 2, 1'b0);
    run_op($urandom, 1, $urandom, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 16));
      run_op($urandom, lat, $urandom, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b1;
    in_data = $urandom;
    cyc();
    in_valid = 1'b0;
    repeat (8) cyc();
    chk("mid_wait_clk_en", ci_clk_en, 1);
    aclr_n = 1'b0;
    #1;
    chk_reset_vals();
    m_ops = 0;
    m_errs = 0;
    @(negedge clock);
    aclr_n = 1'b1;
    #1;
    chk("rel_mid_ci_aclr", ci_aclr, 1);
    cyc();
    chk("rel_mid_ci_aclr2", ci_aclr, 0);
    chk("rel_mid_out_valid", out_valid, 0);
    chk("rel_mid_op_count", op_count, 0);
    run_op($urandom, 17, $urandom, 1, 1'b0);
    for (int i = 0; i < 300; i++) run_op($urandom, 0, 32'd0, 0, 1'b0);
    chk("err_saturated", err_count, 8'hFF);
    run_op($urandom, 5, $urandom, 0, 1'b0);
    chk("err_sat_hold", err_count, 8'hFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
